// File: rtl/alu_opb_stage.sv
// Operand-B stage: rs2 forwarding, imm/rs2 select and load-use stall feeding a 1-deep EX-input register; latency 1 cycle.
// Backpressure: in_ready drops on a load-use hazard, on flush, or while the register is full and EX is not consuming.
module alu_opb_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RAW   = 5,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RAW-1:0]   rs2_addr,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic             opb_sel,
    input  logic             fw1_en,
    input  logic [RAW-1:0]   fw1_addr,
    input  logic [WIDTH-1:0] fw1_data,
    input  logic             fw1_pending,
    input  logic             fw2_en,
    input  logic [RAW-1:0]   fw2_addr,
    input  logic [WIDTH-1:0] fw2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] opb_out,
    output logic [WIDTH-1:0] rs2_out,
    output logic [CNTW-1:0]  stall_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] opb;
        logic [WIDTH-1:0] rs2;
    } opset_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t           state;
    opset_t           held;
    opset_t           next_set;
    logic             fw1_hit;
    logic             fw2_hit;
    logic             hazard;
    logic             accept;
    logic [WIDTH-1:0] rs2_fw;

    // x0 is hard-wired, so a producer targeting it must never win the compare.
    always_comb begin
        fw1_hit = fw1_en && (fw1_addr == rs2_addr) && (rs2_addr != '0);
        fw2_hit = fw2_en && (fw2_addr == rs2_addr) && (rs2_addr != '0);
        rs2_fw  = rs2_data;
        if (fw1_hit) begin
            rs2_fw = fw1_data;
        end else if (fw2_hit) begin
            rs2_fw = fw2_data;
        end
        next_set.rs2 = rs2_fw;
        next_set.opb = opb_sel ? imm_ext : rs2_fw;
    end

    // Store data always needs rs2, so the stall ignores opb_sel.
    assign hazard    = in_valid && fw1_hit && fw1_pending;
    assign out_valid = (state == FULL);
    assign in_ready  = !rst && !hazard && !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign opb_out   = held.opb;
    assign rs2_out   = held.rs2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            held  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (!flush && accept) begin
                        held  <= next_set;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (flush) begin
                        state <= EMPTY;
                    end else if (out_ready) begin
                        if (accept) begin
                            held <= next_set;
                        end else begin
                            state <= EMPTY;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alu_opb_stage.sv
// Directed bench for alu_opb_stage: expected operand sets are queued at issue and popped by a monitor on each EX transfer.
module tb_alu_opb_stage;

    logic        clk;
    logic        rst;
    logic        rst_sat;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic [31:0] imm_ext;
    logic        opb_sel;
    logic        fw1_en;
    logic [4:0]  fw1_addr;
    logic [31:0] fw1_data;
    logic        fw1_pending;
    logic        fw2_en;
    logic [4:0]  fw2_addr;
    logic [31:0] fw2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opb_out;
    logic [31:0] rs2_out;
    logic [15:0] stall_cnt;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_opb_out;
    logic [31:0] sat_rs2_out;
    logic [1:0]  sat_stall_cnt;

    int          total;
    int          passed;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    alu_opb_stage #(.WIDTH(32), .RAW(5), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .imm_ext(imm_ext), .opb_sel(opb_sel),
        .fw1_en(fw1_en), .fw1_addr(fw1_addr), .fw1_data(fw1_data), .fw1_pending(fw1_pending),
        .fw2_en(fw2_en), .fw2_addr(fw2_addr), .fw2_data(fw2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .opb_out(opb_out), .rs2_out(rs2_out),
        .stall_cnt(stall_cnt)
    );

    alu_opb_stage #(.WIDTH(32), .RAW(5), .CNTW(2)) u_sat (
        .clk(clk), .rst(rst_sat), .in_valid(in_valid), .in_ready(sat_in_ready),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .imm_ext(imm_ext), .opb_sel(opb_sel),
        .fw1_en(fw1_en), .fw1_addr(fw1_addr), .fw1_data(fw1_data), .fw1_pending(fw1_pending),
        .fw2_en(fw2_en), .fw2_addr(fw2_addr), .fw2_data(fw2_data), .flush(flush),
        .out_valid(sat_out_valid), .out_ready(out_ready), .opb_out(sat_opb_out), .rs2_out(sat_rs2_out),
        .stall_cnt(sat_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got opb=%h rs2=%h, expected no transfer", opb_out, rs2_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (opb_out == mon_e[63:32] && rs2_out == mon_e[31:0]) begin
                    passed++;
                end else begin
                    $display("FAIL sb_data: got opb=%h rs2=%h, expected opb=%h rs2=%h",
                             opb_out, rs2_out, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic sel, input logic [4:0] a, input logic [31:0] rd,
                         input logic [31:0] imm, input logic [31:0] e_opb, input logic [31:0] e_rs2);
        int n;
        opb_sel  = sel;
        rs2_addr = a;
        rs2_data = rd;
        imm_ext  = imm;
        in_valid = 1'b1;
        exp_q.push_back({e_opb, e_rs2});
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL offer_timeout: in_ready stayed 0, expected 1 within 20 cycles");
            void'(exp_q.pop_back());
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        rst_sat = 1'b1;
        in_valid = 1'b0;
        rs2_addr = '0;
        rs2_data = '0;
        imm_ext = '0;
        opb_sel = 1'b0;
        fw1_en = 1'b0;
        fw1_addr = '0;
        fw1_data = '0;
        fw1_pending = 1'b0;
        fw2_en = 1'b0;
        fw2_addr = '0;
        fw2_data = '0;
        flush = 1'b0;
        out_ready = 1'b1;

        tick();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_opb", opb_out, 32'd0);
        check("reset_rs2", rs2_out, 32'd0);
        check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        rst_sat = 1'b0;

        // basic select
        offer(1'b1, 5'd3, 32'h11, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h11);
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_opb", opb_out, 32'hFFFF_FFF0);
        offer(1'b0, 5'd3, 32'h11, 32'hFFFF_FFF0, 32'h11, 32'h11);

        // forwarding priority
        fw1_en = 1'b1; fw1_addr = 5'd5; fw1_data = 32'hAAAA;
        fw2_en = 1'b1; fw2_addr = 5'd5; fw2_data = 32'hBBBB;
        offer(1'b0, 5'd5, 32'h55, 32'h0, 32'hAAAA, 32'hAAAA);
        offer(1'b1, 5'd5, 32'h55, 32'h0000_0123, 32'h0000_0123, 32'hAAAA);
        fw1_en = 1'b0;
        offer(1'b0, 5'd5, 32'h55, 32'h0, 32'hBBBB, 32'hBBBB);
        fw1_en = 1'b1; fw1_addr = 5'd0; fw2_addr = 5'd0;
        offer(1'b0, 5'd0, 32'h77, 32'h0, 32'h77, 32'h77);
        fw1_en = 1'b0; fw2_en = 1'b0;

        // load-use hazard for three cycles
        check("cnt_before_loaduse", {16'd0, stall_cnt}, 32'd0);
        fw1_en = 1'b1; fw1_addr = 5'd7; fw1_pending = 1'b1; fw1_data = 32'hDEAD;
        opb_sel = 1'b0; rs2_addr = 5'd7; rs2_data = 32'h70; in_valid = 1'b1;
        exp_q.push_back({32'h1234, 32'h1234});
        for (int i = 0; i < 3; i++) begin
            #1;
            check("loaduse_stall", {31'd0, in_ready}, 32'd0);
            tick();
        end
        fw1_pending = 1'b0;
        fw1_data = 32'h1234;
        #1;
        check("loaduse_release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        fw1_en = 1'b0;
        check("loaduse_cnt", {16'd0, stall_cnt}, 32'd3);
        check("loaduse_rs2", rs2_out, 32'h1234);

        // backpressure and no-bubble handover
        tick();
        out_ready = 1'b0;
        offer(1'b1, 5'd2, 32'h21, 32'hA1, 32'hA1, 32'h21);
        opb_sel = 1'b0; rs2_addr = 5'd3; rs2_data = 32'hB3; in_valid = 1'b1;
        exp_q.push_back({32'hB3, 32'hB3});
        for (int i = 0; i < 2; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_opb", opb_out, 32'hA1);
            check("bp_hold_rs2", rs2_out, 32'h21);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_no_bubble_valid", {31'd0, out_valid}, 32'd1);
        check("bp_no_bubble_opb", opb_out, 32'hB3);
        tick();

        // flush while full
        out_ready = 1'b0;
        offer(1'b1, 5'd4, 32'h44, 32'hC0C0, 32'hC0C0, 32'h44);
        opb_sel = 1'b0; rs2_data = 32'hD4; in_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_keep_opb", opb_out, 32'hC0C0);
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        tick();

        // flush coincident with a hazard still counts the stall
        in_valid = 1'b1; rs2_addr = 5'd9; fw1_en = 1'b1; fw1_addr = 5'd9; fw1_pending = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; fw1_en = 1'b0; fw1_pending = 1'b0;
        check("flush_hazard_cnt", {16'd0, stall_cnt}, 32'd4);
        check("flush_hazard_valid", {31'd0, out_valid}, 32'd0);

        // asynchronous reset mid-hazard while full
        out_ready = 1'b0;
        offer(1'b1, 5'd6, 32'h66, 32'hE6E6, 32'hE6E6, 32'h66);
        in_valid = 1'b1; rs2_addr = 5'd7; fw1_en = 1'b1; fw1_addr = 5'd7; fw1_pending = 1'b1;
        tick();
        check("pre_reset_cnt", {16'd0, stall_cnt}, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_opb", opb_out, 32'd0);
        check("arst_rs2", rs2_out, 32'd0);
        check("arst_cnt", {16'd0, stall_cnt}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        void'(exp_q.pop_front());
        in_valid = 1'b0; fw1_en = 1'b0; fw1_pending = 1'b0;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // saturation of a 2-bit counter over a 5-cycle hazard
        rst_sat = 1'b1;
        #1;
        rst_sat = 1'b0;
        in_valid = 1'b1; rs2_addr = 5'd7; fw1_en = 1'b1; fw1_addr = 5'd7; fw1_pending = 1'b1;
        repeat (3) tick();
        check("sat_cnt_3", {30'd0, sat_stall_cnt}, 32'd3);
        repeat (2) tick();
        check("sat_cnt_hold", {30'd0, sat_stall_cnt}, 32'd3);
        check("wide_cnt_5", {16'd0, stall_cnt}, 32'd5);
        in_valid = 1'b0; fw1_en = 1'b0; fw1_pending = 1'b0;

        repeat (4) tick();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
